// File: rtl/abs_pkg.sv
// abs_pkg: shared types and default constants for the ABS controller.
//   abs_state_e     - 2-bit FSM state (IDLE, BRAKE, LOCK, EMERGENCY)
//   *_DEF           - default values for the controller parameters
//   abs_cnt_width() - phase counter width, never less than 1 bit
package abs_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BRAKE     = 2'd1,
        LOCK      = 2'd2,
        EMERGENCY = 2'd3
    } abs_state_e;

    localparam int unsigned SPEED_THRESHOLD_DEF = 20;
    localparam int unsigned RELEASE_CYCLES_DEF  = 3;
    localparam int unsigned APPLY_CYCLES_DEF    = 3;

    // clog2 of the longer phase; a 1-cycle phase would give 0 bits, so clamp.
    function automatic int unsigned abs_cnt_width(input int unsigned rel,
                                                  input int unsigned app);
        int unsigned m;
        m = (rel > app) ? rel : app;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/abs_phase_timer.sv
// abs_phase_timer: loadable down-counter timing the ABS apply/release phases.
//   clk, rst      - clock, async active-high reset (count -> 0)
//   load_i        - load load_val_i (takes priority over decrement)
//   load_val_i    - value to load; 0 is used to clear
//   dec_i         - decrement by one
//   zero_o        - count is zero
module abs_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)     cnt_d = load_val_i;
        else if (dec_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/abs_controller.sv
// abs_controller: single-wheel anti-lock braking controller.
//   clk, rst        - clock, async active-high reset
//   brake_pedal     - driver brake request (level)
//   Object_detected - obstacle flag; forces EMERGENCY full braking
//   wheel_speed     - unsigned 8-bit wheel speed sample
//   brake_signal    - registered actuator command, 1 = apply
// Build option: define ABS_OBJECT_DETECT_EN to enable the obstacle path.
// Without it Object_detected is ignored and EMERGENCY logic is not built.
module abs_controller
    import abs_pkg::*;
#(
    parameter int unsigned SPEED_THRESHOLD = SPEED_THRESHOLD_DEF,
    parameter int unsigned RELEASE_CYCLES  = RELEASE_CYCLES_DEF,
    parameter int unsigned APPLY_CYCLES    = APPLY_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brake_pedal,
    input  logic       Object_detected,
    input  logic [7:0] wheel_speed,
    output logic       brake_signal
);

    localparam int unsigned CW = abs_cnt_width(RELEASE_CYCLES, APPLY_CYCLES);
    localparam logic [CW-1:0] REL_LD = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] APP_LD = CW'(APPLY_CYCLES - 1);
    // 9 bits so a threshold of 256 still compares correctly against 8-bit speed
    localparam logic [8:0]    THR    = 9'(SPEED_THRESHOLD);

    abs_state_e    state_q, state_d;
    logic          brake_q, brake_d;
    logic          ld, dec, cnt_zero;
    logic [CW-1:0] ld_val;
    logic          speed_low;

    assign speed_low = ({1'b0, wheel_speed} < THR);

    abs_phase_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ld),
        .load_val_i (ld_val),
        .dec_i      (dec),
        .zero_o     (cnt_zero)
    );

    // Next state and timer control. A load of 0 is how the counter clears.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_val  = '0;
        dec     = 1'b0;
`ifdef ABS_OBJECT_DETECT_EN
        if (Object_detected) begin
            state_d = EMERGENCY;
            ld      = 1'b1;
        end else
`endif
        begin
            case (state_q)
                IDLE: begin
                    if (brake_pedal) begin
                        state_d = BRAKE;
                        ld      = 1'b1;
                        ld_val  = APP_LD;
                    end
                end
                BRAKE: begin
                    if (!brake_pedal) begin
                        state_d = IDLE;
                        ld      = 1'b1;
                    end else if (!cnt_zero) begin
                        dec = 1'b1;
                    end else if (speed_low) begin
                        state_d = LOCK;
                        ld      = 1'b1;
                        ld_val  = REL_LD;
                    end
                end
                LOCK: begin
                    if (!brake_pedal) begin
                        state_d = IDLE;
                        ld      = 1'b1;
                    end else if (!cnt_zero) begin
                        dec = 1'b1;
                    end else begin
                        state_d = BRAKE;
                        ld      = 1'b1;
                        ld_val  = APP_LD;
                    end
                end
                EMERGENCY: begin
`ifdef ABS_OBJECT_DETECT_EN
                    // counter is already 0 here, so a held pedal with a slow
                    // wheel may go straight into LOCK on the next evaluation
                    state_d = brake_pedal ? BRAKE : IDLE;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign brake_d = (state_d == BRAKE) || (state_d == EMERGENCY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            brake_q <= brake_d;
        end
    end

    assign brake_signal = brake_q;

`ifndef ABS_OBJECT_DETECT_EN
    logic unused_obj;
    assign unused_obj = Object_detected;
`endif

endmodule

// File: tb/tb_abs_controller.sv
module tb_abs_controller;

    localparam int THR = 20;
    localparam int REL = 3;
    localparam int APP = 3;
`ifdef ABS_OBJECT_DETECT_EN
    localparam bit OBJ_EN = 1'b1;
`else
    localparam bit OBJ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       brake_pedal = 1'b0;
    logic       Object_detected = 1'b0;
    logic [7:0] wheel_speed = 8'd50;
    logic       brake_signal;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    abs_controller dut (
        .clk             (clk),
        .rst             (rst),
        .brake_pedal     (brake_pedal),
        .Object_detected (Object_detected),
        .wheel_speed     (wheel_speed),
        .brake_signal    (brake_signal)
    );

    always #5 clk = ~clk;

    // Reference model: mode plus number of cycles spent in the current phase.
    // mode: 0 idle, 1 applying, 2 released, 3 emergency
    int mode = 0;
    int held = 0;

    function automatic void model_reset();
        mode = 0;
        held = 0;
    endfunction

    function automatic bit model_step(input bit p, input bit o, input int s);
        if (OBJ_EN && o) begin
            mode = 3;
        end else if (mode == 3) begin
            // leaving emergency: apply window counts as already served
            mode = p ? 1 : 0;
            held = APP;
        end else if (!p) begin
            mode = 0;
        end else if (mode == 0) begin
            mode = 1;
            held = 1;
        end else if (mode == 1) begin
            if (held >= APP && s < THR) begin
                mode = 2;
                held = 1;
            end else if (held < APP) begin
                held++;
            end
        end else begin
            if (held >= REL) begin
                mode = 1;
                held = 1;
            end else begin
                held++;
            end
        end
        return (mode == 1) || (mode == 3);
    endfunction

    // One clock of stimulus; expected output after the next rising edge is queued.
    task automatic cyc(input bit r, input bit p, input bit o, input int s);
        @(negedge clk);
        rst             = r;
        brake_pedal     = p;
        Object_detected = o;
        wheel_speed     = 8'(s);
        if (r) begin
            model_reset();
            exp_q.push_back(1'b0);
        end else begin
            exp_q.push_back(model_step(p, o, s));
        end
    endtask

    task automatic hold(input int n, input bit p, input bit o, input int s);
        for (int i = 0; i < n; i++) cyc(1'b0, p, o, s);
    endtask

    // Drive pedal+low speed until the model reaches the wanted mode (bounded).
    task automatic run_until(input int want);
        int k;
        k = 0;
        while (mode != want && k < 50) begin
            cyc(1'b0, 1'b1, 1'b0, 15);
            k++;
        end
        total++;
        if (mode != want) begin
            bad++;
            $display("FAIL run_until: model mode %0d, wanted %0d", mode, want);
        end
    endtask

    // Monitor: compare each registered output against the scoreboard.
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (brake_signal !== e) begin
                    bad++;
                    $display("FAIL brake_signal @%0t: got %b expected %b", $time, brake_signal, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset with wheel moving, then idle
        cyc(1'b1, 1'b0, 1'b0, 50);
        cyc(1'b1, 1'b0, 1'b0, 50);
        hold(5, 1'b0, 1'b0, 50);
        // normal braking, no lock
        hold(6, 1'b1, 1'b0, 50);
        // lock pulsing
        hold(20, 1'b1, 1'b0, 15);
        // speed exactly at threshold: no pulsing
        run_until(1);
        hold(8, 1'b1, 1'b0, 20);
        // zero speed keeps pulsing
        hold(12, 1'b1, 1'b0, 0);
        // pedal release during release phase
        run_until(2);
        hold(10, 1'b0, 1'b0, 50);
        // obstacle with pedal released, slow wheel
        hold(5, 1'b0, 1'b1, 15);
        hold(3, 1'b0, 1'b0, 15);
        // obstacle rises as pedal drops during LOCK
        hold(1, 1'b1, 1'b0, 50);
        run_until(2);
        hold(1, 1'b0, 1'b1, 15);
        hold(2, 1'b0, 1'b0, 50);
        // emergency exit with pedal held and slow wheel
        hold(3, 1'b1, 1'b1, 15);
        hold(8, 1'b1, 1'b0, 15);
        // asynchronous reset mid-pulse while applying
        hold(2, 1'b0, 1'b0, 50);
        hold(1, 1'b1, 1'b0, 15);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (brake_signal !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got %b expected 0", brake_signal);
        end
        model_reset();
        exp_q.push_back(1'b0);
        hold(3, 1'b1, 1'b0, 15);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit r, p, o;
            int s;
            r = ($urandom_range(0, 99) < 2);
            p = ($urandom_range(0, 99) < 80);
            o = ($urandom_range(0, 99) < 10);
            s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(10, 30);
            cyc(r, p, o, s);
        end
        hold(2, 1'b0, 1'b0, 50);
        // drain scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/abs_controller.md
# abs_controller

Anti-lock braking controller for a single wheel channel. It turns the driver brake pedal, an obstacle-detect flag and an 8-bit wheel-speed sample into one brake actuator command. When it detects wheel lock-up, it pulses the brake with release/apply cycles. When an obstacle is flagged, it forces a full stop. It sits between the sensor front-end and the brake actuator driver.

## Interface
- SPEED_THRESHOLD, default 20: wheel speed strictly below this value while braking means lock-up.
- RELEASE_CYCLES, default 3: number of cycles the brake is released per ABS pulse.
- APPLY_CYCLES, default 3: minimum number of cycles the brake is re-applied before lock can be detected again.
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- brake_pedal, input, 1: driver brake request, level.
- Object_detected, input, 1: obstacle flag, level; requests an emergency stop.
- wheel_speed, input, 8: unsigned wheel speed, sampled every cycle.
- brake_signal, output, 1: brake actuator command; 1 = apply.

## Operation
- The FSM has four states: IDLE, BRAKE, LOCK, EMERGENCY. A down-counter times the phases.
- brake_signal is decoded from state: 1 in BRAKE and EMERGENCY, 0 in IDLE and LOCK.
- Transitions are evaluated in priority order, highest first:
  - Object_detected = 1, from any state → EMERGENCY.
  - In EMERGENCY with Object_detected = 0 → BRAKE if brake_pedal = 1, else IDLE.
  - brake_pedal = 0 in BRAKE or LOCK → IDLE. The counter clears.
  - IDLE with brake_pedal = 1 → BRAKE. The counter loads APPLY_CYCLES−1.
  - BRAKE, counter = 0 and wheel_speed < SPEED_THRESHOLD → LOCK. The counter loads RELEASE_CYCLES−1.
  - BRAKE with counter ≠ 0 → stays in BRAKE. The counter decrements.
  - LOCK, counter = 0 → BRAKE. The counter loads APPLY_CYCLES−1.
  - LOCK with counter ≠ 0 → stays in LOCK. The counter decrements.
- Comparison is unsigned and strict. wheel_speed = SPEED_THRESHOLD is not lock.
- Sustained low speed with the pedal held gives a continuous ABS pulse train: RELEASE_CYCLES cycles at 0, then APPLY_CYCLES cycles at 1, repeating.
- A wheel_speed of 0 is treated like any other value below the threshold, so pulsing continues.
- EMERGENCY ignores wheel_speed. The brake stays applied with no pulsing.
- Entering EMERGENCY clears the counter.

## Timing
- Reset values: state = IDLE, counter = 0, brake_signal = 0. These apply asynchronously on rst assertion.
- Inputs are sampled at a rising edge. The resulting state and brake_signal are visible right after that same edge, giving 1-cycle latency from input change to output.
- brake_signal is registered (flopped alongside the state) and glitch-free.
- Simultaneous events follow the priority order above. Object_detected beats pedal release, which beats lock detection.
- Assertion of rst mid-pulse aborts the pulse immediately. After reset release, the first evaluation happens at the next rising edge.
- The counter width is the clog2 of max(RELEASE_CYCLES, APPLY_CYCLES). Both parameters must be ≥ 1.

## Configuration
- The macro is ABS_OBJECT_DETECT_EN.
- With the macro defined: Object_detected behaves as specified above.
- Without the macro: the port still exists but is ignored. EMERGENCY is unreachable, and its logic is not synthesized.

## Structure
- abs_pkg holds:
  - the state enum (IDLE, BRAKE, LOCK, EMERGENCY), 2 bits;
  - the default constants for SPEED_THRESHOLD, RELEASE_CYCLES and APPLY_CYCLES.
- Sub-module abs_phase_timer: a loadable down-counter with load value, decrement enable and a zero flag. The FSM and the output register stay in abs_controller.

## Test plan
- Reset: rst = 1 for 2 cycles with wheel_speed = 50 → brake_signal = 0, state IDLE. After release, with all inputs idle, brake_signal stays 0 for 5 cycles.
- Normal brake: brake_pedal = 1, wheel_speed = 50 → brake_signal = 1 one edge later and held steady for 5 cycles.
- Lock pulsing: the pedal is held and wheel_speed drops to 15 → after the apply window, brake_signal shows 0,0,0 then 1,1,1, repeating. wheel_speed = 20 produces no pulsing.
- Pedal release: brake_pedal = 0 during LOCK with wheel_speed back at 50 → IDLE, brake_signal = 0 within 1 cycle, held for 10 cycles.
- Obstacle: Object_detected = 1 with the pedal released → brake_signal = 1 within 1 cycle, held for 5 cycles regardless of wheel_speed = 15. Clearing it → brake_signal = 0 within 1 cycle. With the macro undefined, brake_signal stays 0 throughout.
- Priority: Object_detected rises in the same cycle the pedal drops during LOCK → EMERGENCY, brake_signal = 1.
